// File: rtl/osd_event_arbiter_if.sv
// Event-source and packetizer-side handshake bundle for osd_event_arbiter.
// The master side is the arbiter; the slave side is the sources plus the packetizer.
interface osd_event_arbiter_if #(
  parameter int SRC_NUM    = 2,
  parameter int DATA_WIDTH = 64,
  parameter int IDX_W      = (SRC_NUM > 1) ? $clog2(SRC_NUM) : 1
);
  logic [SRC_NUM*DATA_WIDTH-1:0] src_data;
  logic [SRC_NUM-1:0]            src_overflow;
  logic [SRC_NUM-1:0]            src_valid;
  logic [SRC_NUM-1:0]            src_ready;
  logic                          event_available;
  logic                          event_consumed;
  logic [DATA_WIDTH-1:0]         data;
  logic                          overflow;
  logic [IDX_W-1:0]              grant_idx;

  modport master (
    input  src_data,
    input  src_overflow,
    input  src_valid,
    output src_ready,
    output event_available,
    input  event_consumed,
    output data,
    output overflow,
    output grant_idx
  );

  modport slave (
    output src_data,
    output src_overflow,
    output src_valid,
    input  src_ready,
    input  event_available,
    output event_consumed,
    input  data,
    input  overflow,
    input  grant_idx
  );
endinterface

// File: rtl/osd_event_arbiter.sv
// Round-robin arbiter sharing one event packetizer among SRC_NUM trace
// sources, with a one-entry holding register and stall gating.
module osd_event_arbiter #(
  parameter int SRC_NUM    = 2,
  parameter int DATA_WIDTH = 64,
  parameter int IDX_W      = (SRC_NUM > 1) ? $clog2(SRC_NUM) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [SRC_NUM-1:0] src_enable,
  input  logic               stall,
  osd_event_arbiter_if.master bus
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t                state;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  ovf_q;
  logic [IDX_W-1:0]      gnt_q;
  logic [IDX_W-1:0]      rr_ptr;

  logic [SRC_NUM-1:0]    elig;
  logic [IDX_W-1:0]      sel;
  logic                  any;
  logic                  can_load;
  logic                  load;
  logic                  drain;
  logic [IDX_W-1:0]      rr_nxt;

  assign elig     = bus.src_valid & src_enable;
  assign can_load = !stall && (state == EMPTY || bus.event_consumed);
  assign load     = can_load && any;
  assign drain    = bus.event_consumed && state == FULL && !load;

  // Scan offsets high to low so the offset nearest rr_ptr wins.
  always_comb begin
    int p;
    sel = '0;
    any = 1'b0;
    p   = 0;
    for (int k = SRC_NUM - 1; k >= 0; k--) begin
      p = int'(rr_ptr) + k;
      if (p >= SRC_NUM)
        p = p - SRC_NUM;
      if (elig[IDX_W'(p)]) begin
        sel = IDX_W'(p);
        any = 1'b1;
      end
    end
  end

  assign rr_nxt = (sel == IDX_W'(SRC_NUM - 1)) ? '0
                                               : sel + IDX_W'(1);

  assign bus.src_ready = (load && !rst) ? (SRC_NUM'(1) << sel)
                                        : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= EMPTY;
      data_q <= '0;
      ovf_q  <= 1'b0;
      gnt_q  <= '0;
      rr_ptr <= '0;
    end else begin
      unique case (1'b1)
        load: begin
          state  <= FULL;
          data_q <= bus.src_data[int'(sel)*DATA_WIDTH +: DATA_WIDTH];
          ovf_q  <= bus.src_overflow[sel];
          gnt_q  <= sel;
          rr_ptr <= rr_nxt;
        end
        drain: begin
          state <= EMPTY;
        end
        default: begin
          state <= state;
        end
      endcase
    end
  end

  assign bus.event_available = (state == FULL);
  assign bus.data            = data_q;
  assign bus.overflow        = ovf_q;
  assign bus.grant_idx       = gnt_q;

endmodule
